// File: rtl/dr_pkg.sv
// Shared types and default sizes for the dual-rail word collector and its helpers.
package dr_pkg;

  localparam int unsigned DEF_WORD_W    = 32;
  localparam int unsigned DEF_NUM_WORDS = 4;
  localparam int unsigned DEF_LATENCY   = 80;
  localparam int unsigned DEF_CNT_W     = 8;

  // Collector control states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COLLECT,
    DONE
  } state_t;

  // Meaning of one rail_1/rail_0 sample pair.
  typedef enum logic [1:0] {
    CODE,     // rail_1 == ~rail_0 : legal data codeword
    SPC0,     // both rails all-zero spacer
    SPC1,     // both rails all-one spacer
    ILLEGAL   // anything else
  } rail_class_t;

endpackage

// File: rtl/dr_word_collector_if.sv
// Bus between a dual-rail source and the word collector: sample rails, spacer
// qualifiers, and the assembled block with its status flags.
interface dr_word_collector_if
  import dr_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter int unsigned CNT_W     = DEF_CNT_W
);

  logic                        start;
  logic [WORD_W-1:0]           rail_1;
  logic [WORD_W-1:0]           rail_0;
  logic                        spc_chk;
  logic                        spc_pol;
  logic [WORD_W*NUM_WORDS-1:0] text_out;
  logic                        done;
  logic                        busy;
  logic                        code_err;
  logic                        spc_err;
  logic [CNT_W-1:0]            err_cnt;

  // Driver side (dual-rail core / bench).
  modport master (
    output start, rail_1, rail_0, spc_chk, spc_pol,
    input  text_out, done, busy, code_err, spc_err, err_cnt
  );

  // Collector side.
  modport slave (
    input  start, rail_1, rail_0, spc_chk, spc_pol,
    output text_out, done, busy, code_err, spc_err, err_cnt
  );

endinterface

// File: rtl/dr_classify.sv
// Combinational classifier for one dual-rail sample pair: codeword, either
// spacer, or illegal. Kept separate so encoder-side checks can reuse it.
module dr_classify
  import dr_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) (
  input  logic [WORD_W-1:0] i_rail_1,
  input  logic [WORD_W-1:0] i_rail_0,
  output rail_class_t       o_class
);

  // Codeword test first: an all-zero or all-one pair can never satisfy it.
  always_comb begin
    if (i_rail_1 == ~i_rail_0) begin
      o_class = CODE;
    end else if ((i_rail_1 == '0) && (i_rail_0 == '0)) begin
      o_class = SPC0;
    end else if ((&i_rail_1) && (&i_rail_0)) begin
      o_class = SPC1;
    end else begin
      o_class = ILLEGAL;
    end
  end

endmodule

// File: rtl/dr_word_collector.sv
// Receives dual-rail serial words, checks every sample for legal codewords and
// expected spacers, and assembles NUM_WORDS data words into one single-rail
// block (first word in the MSBs) with a done pulse and error bookkeeping.
module dr_word_collector
  import dr_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter int unsigned LATENCY   = DEF_LATENCY,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  dr_word_collector_if.slave bus
);

  localparam int unsigned       LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned       WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam logic [WCNT_W-1:0] LAST_SLOT = WCNT_W'(NUM_WORDS - 1);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [LAT_W-1:0]               r_lat_cnt;
  logic [WCNT_W-1:0]              r_wcnt;
  logic [WCNT_W-1:0]              w_slot;
  logic [NUM_WORDS-1:0][WORD_W-1:0] r_text;
  logic                           r_pend;
  logic                           r_code_err;
  logic                           r_spc_err;
  logic [CNT_W-1:0]               r_err_cnt;

  rail_class_t                    w_class;
  rail_class_t                    w_spc_exp;
  logic                           w_store;
  logic                           w_last;
  logic                           w_data_bad;
  logic                           w_spc_bad;
  logic                           w_busy;
  logic                           w_done;

  dr_classify #(
    .WORD_W (WORD_W)
  ) u_classify (
    .i_rail_1 (bus.rail_1),
    .i_rail_0 (bus.rail_0),
    .o_class  (w_class)
  );

  // A restart takes priority over a data sample arriving in the same cycle,
  // so an aborting start neither stores nor counts that sample.
  assign w_store    = (r_state == COLLECT) && !bus.start && !bus.spc_chk;
  assign w_last     = (r_wcnt == LAST_SLOT);
  assign w_slot     = LAST_SLOT - r_wcnt;
  assign w_data_bad = w_store && (w_class != CODE);
  assign w_spc_exp  = bus.spc_pol ? SPC1 : SPC0;
  assign w_spc_bad  = bus.spc_chk && (w_class != w_spc_exp);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore outputs; start from any state (re)launches a block.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      WAIT: begin
        w_busy = 1'b1;
        if (r_lat_cnt == '0) begin
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        w_busy = 1'b1;
        if (w_store && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (bus.start) begin
      if (LATENCY == 0) begin
        w_state_nxt = COLLECT;
      end else begin
        w_state_nxt = WAIT;
      end
    end
  end

  // Latency countdown: loaded on start, counts down to zero while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat_cnt <= '0;
    end else if (bus.start) begin
      r_lat_cnt <= LAT_INIT;
    end else if ((r_state == WAIT) && (r_lat_cnt != '0)) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  // Word index: zero outside collection, advances only on stored data samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wcnt <= '0;
    end else if (bus.start || (r_state != COLLECT)) begin
      r_wcnt <= '0;
    end else if (w_store) begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  // Block register: slots are overwritten in place, older contents hold until replaced.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the text block is a flop array rather than a RAM, so it can legitimately take a reset.
    if (reset) begin
      r_text <= '0;
    end else if (w_store) begin
      r_text[w_slot] <= bus.rail_1;
    end
  end

  // Pending and reported codeword error for the block in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend     <= 1'b0;
      r_code_err <= 1'b0;
    end else begin
      if (bus.start) begin
        r_pend <= 1'b0;
      end else if (w_data_bad) begin
        r_pend <= 1'b1;
      end
      if (w_store && w_last) begin
        r_code_err <= r_pend | w_data_bad;
      end
    end
  end

  // Sticky spacer flag and saturating error count; data and spacer cycles are exclusive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spc_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_spc_bad) begin
        r_spc_err <= 1'b1;
      end
      if ((w_data_bad || w_spc_bad) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign bus.text_out = r_text;
  assign bus.done     = w_done;
  assign bus.busy     = w_busy;
  assign bus.code_err = r_code_err;
  assign bus.spc_err  = r_spc_err;
  assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_dr_word_collector.sv
// Self-checking bench for dr_word_collector: directed block scenarios plus
// randomized traffic, compared every cycle against an event-level model.
module tb_dr_word_collector;
  import dr_pkg::*;

  localparam int W       = 32;
  localparam int N       = 4;
  localparam int LAT     = 80;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dr_word_collector_if #(.WORD_W(W), .NUM_WORDS(N), .CNT_W(CW)) bus ();

  dr_word_collector #(
    .WORD_W    (W),
    .NUM_WORDS (N),
    .LATENCY   (LAT),
    .CNT_W     (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works on edge numbers: a block started at edge s stores data samples from
  // edge s+LAT+1 on, and reports done after its N-th stored word.
  logic         s_st, s_sc, s_pol, s_rst = 1'b1;
  logic [W-1:0] s_r1, s_r0;

  int           edge_n = 0;
  bit           m_active;
  int           m_s;
  int           m_k;
  logic [N*W-1:0] m_text;
  bit           m_pend;
  int           m_cnt;
  bit           m_spc_err;
  bit           m_done;
  bit           m_code_err;
  int           n_done_seen = 0;
  int           dut_lat = -1;
  int           mdl_lat = -1;

  always @(posedge clk) begin
    s_st  <= bus.start;
    s_r1  <= bus.rail_1;
    s_r0  <= bus.rail_0;
    s_sc  <= bus.spc_chk;
    s_pol <= bus.spc_pol;
    s_rst <= reset;
  end

  task automatic model_clear();
    m_active = 0; m_k = 0; m_text = '0; m_pend = 0;
    m_cnt = 0; m_spc_err = 0; m_done = 0; m_code_err = 0;
  endtask

  task automatic bump();
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic model_step();
    logic [W-1:0] sp;
    edge_n++;
    m_done = 0;
    sp = s_pol ? '1 : '0;
    if (s_sc && !((s_r1 == sp) && (s_r0 == sp))) begin
      m_spc_err = 1;
      bump();
    end
    if (s_st) begin
      m_active = 1; m_s = edge_n; m_k = 0; m_pend = 0;
    end else if (m_active && !s_sc && (edge_n >= m_s + LAT + 1)) begin
      m_text[(N-1-m_k)*W +: W] = s_r1;
      if (s_r1 != ~s_r0) begin
        m_pend = 1;
        bump();
      end
      m_k++;
      if (m_k == N) begin
        m_done = 1; m_code_err = m_pend; m_active = 0;
      end
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      model_clear();
    end else begin
      if (s_rst) model_clear();
      else       model_step();
      check("done",     bus.done,     m_done);
      check("busy",     bus.busy,     m_active);
      check("spc_err",  bus.spc_err,  m_spc_err);
      check("err_cnt",  bus.err_cnt,  m_cnt[CW-1:0]);
      check("text_out", bus.text_out, m_text);
      if (m_done) begin
        check("code_err", bus.code_err, m_code_err);
        mdl_lat = edge_n - m_s;
      end
      if (bus.done === 1'b1) begin
        n_done_seen++;
        dut_lat = edge_n - m_s;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit st, input logic [W-1:0] r1, input logic [W-1:0] r0,
                     input bit sc, input bit sp);
    bus.start = st; bus.rail_1 = r1; bus.rail_0 = r0; bus.spc_chk = sc; bus.spc_pol = sp;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, '0, '0, 0, 0);
  endtask

  task automatic do_reset();
    bus.start = 0; bus.spc_chk = 0;
    reset = 1'b1;
    #1;
    check("rst_text",  bus.text_out, '0);
    check("rst_done",  bus.done,     '0);
    check("rst_busy",  bus.busy,     '0);
    check("rst_cerr",  bus.code_err, '0);
    check("rst_serr",  bus.spc_err,  '0);
    check("rst_cnt",   bus.err_cnt,  '0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Start, wait out the latency, send N words (bad_mask bit i makes word i illegal),
  // then stop in the done cycle and confirm done landed LAT+N cycles after start.
  task automatic send_block(input logic [N-1:0][W-1:0] ws, input logic [N-1:0] bad_mask);
    logic [W-1:0] w, r0;
    cyc(1, '0, '0, 0, 0);
    idle(LAT);
    for (int i = 0; i < N; i++) begin
      w  = ws[N-1-i];
      r0 = ~w;
      if (bad_mask[i]) r0[5] = ~r0[5];
      cyc(0, w, r0, 0, 0);
    end
    @(negedge clk);
    #1;
    check("blk_done", bus.done, 1'b1);
    check("blk_lat",  dut_lat,  LAT + N);
  endtask

  localparam logic [N-1:0][W-1:0] VEC = {32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0][W-1:0] rw;
    int d0;
    bus.start = 0; bus.rail_1 = '0; bus.rail_0 = '0; bus.spc_chk = 0; bus.spc_pol = 0;
    repeat (3) @(posedge clk);
    #2;
    check("init_text", bus.text_out, '0);
    check("init_cnt",  bus.err_cnt,  '0);
    reset = 1'b0;

    // 1: clean block, done 84 cycles after start.
    send_block(VEC, 4'b0000);
    check("t1_text",    bus.text_out, 128'h3243f6a8885a308d313198a2e0370734);
    check("t1_cerr",    bus.code_err, 1'b0);
    check("t1_busy",    bus.busy,     1'b0);
    check("t1_mdl_lat", mdl_lat,      84);

    // 2: third word illegal.
    do_reset();
    send_block(VEC, 4'b0100);
    check("t2_text", bus.text_out, 128'h3243f6a8885a308d313198a2e0370734);
    check("t2_cerr", bus.code_err, 1'b1);
    check("t2_cnt",  bus.err_cnt,  8'd1);

    // 3: correct spacers with toggling polarity, then one bad spacer.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        if ((i / 2) % 2 == 1) cyc(0, '1, '1, 1, 1);
        else                  cyc(0, '0, '0, 1, 0);
      end else begin
        cyc(0, $urandom, $urandom, 0, 0);
      end
    end
    check("t3_spc_ok",  bus.spc_err, 1'b0);
    check("t3_cnt_ok",  bus.err_cnt, 8'd1);
    cyc(0, '1, '1, 1, 0);
    check("t3_spc_bad", bus.spc_err, 1'b1);
    check("t3_cnt_bad", bus.err_cnt, 8'd2);
    idle(5);
    check("t3_sticky",  bus.spc_err, 1'b1);

    // 4: 300 illegal words saturate the counter.
    do_reset();
    for (int b = 0; b < 75; b++) begin
      for (int i = 0; i < N; i++) rw[i] = $urandom;
      send_block(rw, 4'b1111);
    end
    check("t4_sat", bus.err_cnt, 8'd255);
    cyc(0, '1, '0, 1, 0);
    check("t4_hold", bus.err_cnt, 8'd255);

    // 5: restart 10 cycles into WAIT; only the second block completes.
    do_reset();
    d0 = n_done_seen;
    cyc(1, '0, '0, 0, 0);
    idle(10);
    send_block(VEC, 4'b0000);
    check("t5_ndone", n_done_seen - d0, 1);
    check("t5_text",  bus.text_out, 128'h3243f6a8885a308d313198a2e0370734);

    // 6: reset after two collected words, then a fresh block.
    d0 = n_done_seen;
    cyc(1, '0, '0, 0, 0);
    idle(LAT);
    cyc(0, 32'h01234567, ~32'h01234567, 0, 0);
    cyc(0, 32'h89abcdef, ~32'h89abcdef, 0, 0);
    do_reset();
    idle(3);
    check("t6_ndone", n_done_seen - d0, 0);
    check("t6_busy",  bus.busy, 1'b0);
    for (int i = 0; i < N; i++) rw[i] = $urandom;
    send_block(rw, 4'b0000);
    check("t6_text", bus.text_out, rw);
    check("t6_cerr", bus.code_err, 1'b0);

    // 7: randomized traffic with aborts, illegal words and bad spacers.
    do_reset();
    d0 = n_done_seen;
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] w, r0;
      bit st, sc, sp;
      st = m_active ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 9) == 0);
      sc = ($urandom_range(0, 2) == 0);
      sp = $urandom_range(0, 1);
      if (sc) begin
        if ($urandom_range(0, 29) == 0) begin
          w = $urandom; r0 = $urandom;
        end else begin
          w = sp ? '1 : '0; r0 = w;
        end
      end else begin
        w = $urandom; r0 = ~w;
        if ($urandom_range(0, 24) == 0) r0[$urandom_range(0, W-1)] ^= 1'b1;
      end
      cyc(st, w, r0, sc, sp);
    end
    idle(2);
    check("t7_blocks", (n_done_seen - d0) >= 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
